tpiu_stream_demux: RTL and testbench

Parametrised TPIU frame decoder and stream demultiplexer. It sits above the TPIU frame aligner and below the per-stream consumers (serial/USB packers). Each 16-byte CoreSight formatter frame is captured as eight 16-bit words, then decoded: ID changes are tracked, including delayed changes and the aux-byte LSB reconstruction. Every data byte is routed into per-channel byte FIFOs whose stream IDs are programmable, with saturating overflow counters.

---
 rtl/tpiu_stream_demux.sv | 177 +++++++++++++++++
 tb/tb_tpiu_stream_demux.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpiu_stream_demux.sv
// TPIU formatter frame decoder: captures a 16-byte frame as eight 16-bit words, tracks
// stream ID changes and routes every data byte into per-channel first-word-fall-through FIFOs.
module tpiu_stream_demux #(
    parameter int NUM_CH  = 2,
    parameter int FIFO_AW = 4,
    parameter int OVF_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_word,
    input  logic [NUM_CH*7-1:0]     ch_id,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*8-1:0]     out_data,
    output logic [NUM_CH*OVF_W-1:0] ovf_cnt,
    output logic [6:0]              cur_id
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [OVF_W-1:0]   OVF_ONE  = OVF_W'(1);
    localparam logic [OVF_W-1:0]   OVF_MAX  = '1;

    typedef enum logic {CAPTURE, DECODE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  widx_q, widx_d;
    logic [3:0]  pos_q, pos_d;
    logic [6:0]  cur_id_q, cur_id_d;
    logic [15:0] frame_q [8];
    logic [15:0] frame_d [8];

    logic [7:0]  aux, cur_byte, low_byte, emit_byte;
    logic        aux_bit, emit;

    logic [NUM_CH-1:0]  push_req, push_ok, pop;
    logic [FIFO_AW:0]   cnt_q  [NUM_CH];
    logic [FIFO_AW:0]   cnt_d  [NUM_CH];
    logic [FIFO_AW-1:0] wptr_q [NUM_CH];
    logic [FIFO_AW-1:0] wptr_d [NUM_CH];
    logic [FIFO_AW-1:0] rptr_q [NUM_CH];
    logic [FIFO_AW-1:0] rptr_d [NUM_CH];
    logic [OVF_W-1:0]   ovf_q  [NUM_CH];
    logic [OVF_W-1:0]   ovf_d  [NUM_CH];
    logic [7:0]         mem_q  [NUM_CH][DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CAPTURE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CAPTURE: if (in_valid && in_ready && widx_q == 3'd7) state_d = DECODE;
            DECODE:  if (pos_q == 4'd14) state_d = CAPTURE;
            default: state_d = CAPTURE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == CAPTURE) && sync;
        cur_id    = cur_id_q;
        out_valid = '0;
        out_data  = '0;
        ovf_cnt   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            out_valid[c]              = (cnt_q[c] != '0);
            out_data[8*c +: 8]        = out_valid[c] ? mem_q[c][rptr_q[c]] : 8'h00;
            ovf_cnt[OVF_W*c +: OVF_W] = ovf_q[c];
        end
    end

    always_comb begin
        widx_d  = widx_q;
        pos_d   = pos_q;
        frame_d = frame_q;
        if (state_q == CAPTURE) begin
            pos_d = 4'd0;
            if (!sync) begin
                widx_d = 3'd0;
            end else if (in_valid) begin
                frame_d[widx_q] = in_word;
                widx_d          = widx_q + 3'd1;
            end
        end else begin
            pos_d = (pos_q == 4'd14) ? 4'd0 : pos_q + 4'd1;
        end
    end

    // For odd p the byte before it is the low half of the same word, so a delayed
    // ID change is recovered from the frame buffer instead of a pending register.
    always_comb begin
        aux       = frame_q[7][15:8];
        low_byte  = frame_q[pos_q[3:1]][7:0];
        cur_byte  = pos_q[0] ? frame_q[pos_q[3:1]][15:8] : low_byte;
        aux_bit   = aux[pos_q[3:1]];
        emit      = 1'b0;
        emit_byte = cur_byte;
        cur_id_d  = cur_id_q;
        if (state_q == DECODE) begin
            if (pos_q[0]) begin
                emit = 1'b1;
                if (low_byte[0] && aux_bit) cur_id_d = low_byte[7:1];
            end else if (cur_byte[0]) begin
                if (!aux_bit || pos_q == 4'd14) cur_id_d = cur_byte[7:1];
            end else begin
                emit      = 1'b1;
                emit_byte = {cur_byte[7:1], aux_bit};
            end
            if (pos_q == 4'd14 && !sync) cur_id_d = 7'd0;
        end else if (!sync) begin
            cur_id_d = 7'd0;
        end
    end

    // A push into a FIFO that is already full is dropped even when it is popped in the same cycle.
    always_comb begin
        push_req = '0;
        push_ok  = '0;
        pop      = '0;
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        ovf_d    = ovf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            push_req[c] = emit && ch_en[c] && (ch_id[7*c +: 7] == cur_id_q)
                          && (cur_id_q != 7'h00) && (cur_id_q != 7'h7F);
            push_ok[c]  = push_req[c] && (cnt_q[c] != CNT_FULL);
            pop[c]      = (cnt_q[c] != '0) && out_ready[c];
            if (push_ok[c]) wptr_d[c] = wptr_q[c] + PTR_ONE;
            if (pop[c])     rptr_d[c] = rptr_q[c] + PTR_ONE;
            case ({push_ok[c], pop[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
                2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
                default: cnt_d[c] = cnt_q[c];
            endcase
            if (push_req[c] && !push_ok[c] && ovf_q[c] != OVF_MAX) ovf_d[c] = ovf_q[c] + OVF_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx_q   <= 3'd0;
            pos_q    <= 4'd0;
            cur_id_q <= 7'd0;
            for (int i = 0; i < 8; i++) frame_q[i] <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]  <= '0;
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                ovf_q[c]  <= '0;
            end
        end else begin
            widx_q   <= widx_d;
            pos_q    <= pos_d;
            cur_id_q <= cur_id_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: contents are only visible while the occupancy count is non-zero.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (push_ok[c]) mem_q[c][wptr_q[c]] <= emit_byte;
    end

endmodule

// File: tb/tb_tpiu_stream_demux.sv
// Scoreboard bench for tpiu_stream_demux: a frame-level reference model queues the expected
// bytes per channel, and an independent monitor pops and compares them as the DUT emits.
module tb_tpiu_stream_demux;
    localparam int NUM_CH  = 2;
    localparam int FIFO_AW = 2;
    localparam int OVF_W   = 8;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sync;
    logic                    in_valid;
    logic                    in_ready;
    logic [15:0]             in_word;
    logic [NUM_CH*7-1:0]     ch_id;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    logic [NUM_CH*8-1:0]     out_data;
    logic [NUM_CH*OVF_W-1:0] ovf_cnt;
    logic [6:0]              cur_id;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    logic [6:0]  model_id;
    int          model_ovf [NUM_CH];
    logic [15:0] frm [8];
    logic [6:0]  id_set [6];

    always #5 clk = ~clk;

    tpiu_stream_demux #(.NUM_CH(NUM_CH), .FIFO_AW(FIFO_AW), .OVF_W(OVF_W)) dut (
        .clk(clk), .rst(rst), .sync(sync), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .ch_id(ch_id), .ch_en(ch_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .ovf_cnt(ovf_cnt), .cur_id(cur_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int qsize(input int c);
        return (c == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic qpush(input int c, input logic [7:0] b);
        if (c == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    function automatic logic [7:0] qpop(input int c);
        if (c == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic model_deliver(input logic [7:0] data);
        if (model_id == 7'h00 || model_id == 7'h7F) return;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_en[c] && ch_id[7*c +: 7] == model_id) begin
                if (!out_ready[c] && qsize(c) >= DEPTH) begin
                    if (model_ovf[c] < 255) model_ovf[c]++;
                end else begin
                    qpush(c, data);
                end
            end
        end
    endtask

    // Walk the frame as a byte stream; a delayed change is held until one more byte has gone out.
    task automatic model_frame();
        logic [7:0] b [16];
        logic [7:0] aux;
        logic [6:0] pend;
        bit         has_pend;
        for (int i = 0; i < 8; i++) begin
            b[2*i]   = frm[i][7:0];
            b[2*i+1] = frm[i][15:8];
        end
        aux      = b[15];
        has_pend = 0;
        pend     = 7'd0;
        for (int p = 0; p < 15; p++) begin
            if (p % 2 == 0 && b[p][0]) begin
                if (aux[p/2] && p != 14) begin
                    pend     = b[p][7:1];
                    has_pend = 1;
                end else begin
                    model_id = b[p][7:1];
                end
            end else begin
                model_deliver((p % 2 == 0) ? {b[p][7:1], aux[p/2]} : b[p]);
                if (has_pend) begin
                    model_id = pend;
                    has_pend = 0;
                end
            end
        end
    endtask

    task automatic send_word(input logic [15:0] w, input int max_gap);
        bit acc = 0;
        in_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_word  = w;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // mode 0: plain frame, 1: sync dropped during decode, 2: reset at decode cycle 5
    task automatic applyStimulus(input int mode, input int max_gap);
        model_frame();
        for (int i = 0; i < 8; i++) send_word(frm[i], max_gap);
        if (mode == 1) begin
            sync     = 1'b0;
            model_id = 7'd0;
        end else if (mode == 2) begin
            repeat (5) begin @(posedge clk); #1; end
            rst = 1'b1;
            #1;
            exp_q0.delete();
            exp_q1.delete();
            model_id = 7'd0;
            for (int c = 0; c < NUM_CH; c++) model_ovf[c] = 0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
            check("rst_cur_id", 32'(cur_id), 32'd0);
            repeat (2) begin @(posedge clk); #1; end
            rst = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        bit drained = 0;
        repeat (17) begin @(posedge clk); #1; end
        for (int t = 0; t < 200 && !drained; t++) begin
            drained = 1;
            for (int c = 0; c < NUM_CH; c++)
                if (out_ready[c] && qsize(c) != 0) drained = 0;
            if (!drained) begin @(posedge clk); #1; end
        end
        check({tag, "_drain"}, 32'(drained), 32'd1);
        check({tag, "_leftover"}, 32'(out_valid & out_ready), 32'd0);
        check({tag, "_cur_id"}, 32'(cur_id), 32'(model_id));
        for (int c = 0; c < NUM_CH; c++)
            check({tag, "_ovf"}, 32'(ovf_cnt[OVF_W*c +: OVF_W]), 32'(model_ovf[c]));
    endtask

    task automatic load_basic();
        frm[0] = 16'h1103;
        frm[1] = 16'h2222;
        for (int i = 2; i < 7; i++) frm[i] = 16'h3344;
        frm[7] = 16'h0066;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] r;
        r = 8'($urandom());
        if ($urandom_range(0, 2) == 0) return {id_set[$urandom_range(0, 5)], 1'b1};
        return r;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (out_valid[c] && out_ready[c]) begin
                        if (qsize(c) == 0) begin
                            check("unexpected_byte", 32'(out_data[8*c +: 8]), 32'hFFFF_FFFF);
                        end else begin
                            check("byte_data", 32'(out_data[8*c +: 8]), 32'(qpop(c)));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        id_set = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h7F, 7'h04};
        rst = 1'b1; sync = 1'b0; in_valid = 1'b0; in_word = '0;
        ch_id = '0; ch_en = '0; out_ready = '1;
        model_id = 7'd0;
        for (int c = 0; c < NUM_CH; c++) model_ovf[c] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready_nosync", 32'(in_ready), 32'd0);
        sync = 1'b1;
        #1;
        check("reset_in_ready_sync", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_ovf", 32'(ovf_cnt), 32'd0);
        check("reset_cur_id", 32'(cur_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        ch_id = {7'd2, 7'd1};
        ch_en = 2'b11;
        load_basic();
        applyStimulus(0, 0);
        checkOutput("basic");

        frm[7] = 16'h0266;
        applyStimulus(0, 2);
        checkOutput("lsb");

        frm[1] = 16'h5505;
        applyStimulus(0, 1);
        checkOutput("delayed");

        load_basic();
        out_ready = 2'b10;
        applyStimulus(0, 0);
        checkOutput("overflow");
        check("ovf_head_data", 32'(out_data[7:0]), 32'h11);
        out_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ovf_pop_valid", 32'(out_valid[0]), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("ovf_pop_empty", 32'(out_valid[0]), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) send_word(frm[i], 0);
        sync = 1'b0;
        model_id = 7'd0;
        repeat (3) begin @(posedge clk); #1; end
        check("syncloss_cur_id", 32'(cur_id), 32'd0);
        check("syncloss_in_ready", 32'(in_ready), 32'd0);
        sync = 1'b1;
        frm[0] = 16'h1144;
        applyStimulus(0, 0);
        checkOutput("syncloss");
        check("syncloss_quiet", 32'(out_valid), 32'd0);

        load_basic();
        applyStimulus(1, 0);
        checkOutput("decode_syncdrop");
        sync = 1'b1;

        applyStimulus(2, 0);
        applyStimulus(0, 0);
        checkOutput("after_reset");

        for (int f = 0; f < 40; f++) begin
            int mode;
            for (int c = 0; c < NUM_CH; c++) ch_id[7*c +: 7] = id_set[$urandom_range(0, 5)];
            ch_en = NUM_CH'($urandom());
            for (int i = 0; i < 8; i++) frm[i] = {rand_byte(), rand_byte()};
            mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
            applyStimulus(mode, 2);
            checkOutput("random");
            sync = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
